sobel_stream: RTL and testbench
===============================

# sobel_stream

Streaming, parametrised successor to the combinational 3×3 Sobel core. It accepts a raster-order pixel stream over a valid/ready handshake and keeps two internal line buffers to form the 3×3 window itself. The gradient is computed in a two-stage pipeline, and one result is produced per accepted input pixel. It sits between the pixel source (camera/SPI front end) and the output formatter, and adds selectable output modes and backpressure.

## Interface
- PIXEL_WIDTH, 8: input pixel width, unsigned.
- LINE_WIDTH, 64: pixels per image line (≥3); sets line-buffer depth.
- OUT_WIDTH, 8: output pixel width, unsigned.
- clk_i  in  1  single clock, rising edge.
- nreset_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  frame start, synchronous pulse.
- in_valid_i  in  1  input pixel valid.
- in_pixel_i  in  PIXEL_WIDTH  input pixel, unsigned.
- in_ready_o  out  1  block can accept a pixel this cycle.
- mode_i  in  2  0 = |Gx|+|Gy|, 1 = |Gx|, 2 = |Gy|, 3 = threshold.
- threshold_i  in  OUT_WIDTH  threshold for mode 3.
- out_valid_o  out  1  result valid.
- out_pixel_o  out  OUT_WIDTH  result pixel.
- out_ready_i  in  1  sink accepts the result.

## Operation
- An input beat is accepted on in_valid_i & in_ready_o. An output beat is transferred on out_valid_o & out_ready_i.
- The column counter runs 0..LINE_WIDTH-1 and wraps to 0. The row counter increments on each wrap and saturates at 2; only the row≥2 condition matters.
- start_i clears both counters. A beat accepted in the same cycle is pixel (0,0) of the new frame. Line-buffer contents are not cleared. In-flight results drain normally.
- Window p[r][c]: r=0 is the oldest row (line buffer 2), r=2 is the current row; c=0 is the oldest column, c=2 is the current pixel.
- Gx = (p02−p00) + 2(p12−p10) + (p22−p20).
- Gy = (p20−p00) + 2(p21−p01) + (p22−p02).
- Gradients are signed and PIXEL_WIDTH+3 bits wide. Magnitudes are unsigned and PIXEL_WIDTH+3 bits wide; the magnitude sum is unsigned and PIXEL_WIDTH+4 bits wide. No internal overflow is permitted.
- Saturation: any value > 2^OUT_WIDTH−1 becomes all-ones.
- Mode 3 compares the saturated |Gx|+|Gy| against threshold_i: ≥ threshold gives all-ones, otherwise 0.
- Border: if the beat's row<2 or col<2, the result is 0 for every mode, including mode 3.
- mode_i and threshold_i are captured with each accepted beat. A change mid-stream affects only later beats.

## Timing
- Stage 1 registers the window, the border flag and the captured mode/threshold, and computes Gx/Gy. Stage 2 registers abs, sum, saturation and mode into out_pixel_o.
- Latency: a beat accepted at edge N appears with out_valid_o=1 after edge N+2, provided there is no stall.
- Global stall: advance = !(out_valid_o & !out_ready_i). When the pipeline stalls, all stages, counters and line buffers hold.
- in_ready_o = advance, combinational.
- Bubbles (in_valid_i=0 while advancing) propagate as invalid slots. out_valid_o never drops while out_ready_i=0.
- Reset values: out_valid_o=0, out_pixel_o=0, counters=0, stage valids=0. Consequently in_ready_o=1.
- Reset mid-frame discards all in-flight data. The next accepted beat is pixel (0,0).
- Simultaneous start_i and stall: start_i still clears the counters. It is not gated by advance.

## Structure
- Package sobel_pkg holds:
  - the mode enum (SOBEL_SUM, SOBEL_GX, SOBEL_GY, SOBEL_THRESH);
  - width localparams GRAD_WIDTH = PIXEL_WIDTH+3 and SUM_WIDTH = PIXEL_WIDTH+4;
  - a saturate function.
- One sub-module, sobel_line_buffer: a LINE_WIDTH-deep, PIXEL_WIDTH-wide shift memory with write enable. It is instantiated twice and chained.
- Counters, window registers and the two pipeline stages live in sobel_stream.

## Test plan
- LINE_WIDTH=8, 6 lines, all pixels 100, mode 0 → all 48 outputs are 0, in input order, with latency 2.
- Horizontal ramp (pixel = col) → interior outputs are 8 in modes 0 and 1, and 0 in mode 2. Outputs with row<2 or col<2 are 0.
- Vertical step (cols 0–3 = 0, cols 4–7 = 255), mode 0 → outputs at the step edge are 255 (Gx=1020, saturated). Mode 2 on the same image → 0.
- Ramp image, mode 3: threshold 8 → interior outputs 255; threshold 9 → 0. Border outputs stay 0 in both cases.
- Hold out_ready_i=0 for 5 cycles while streaming → in_ready_o=0 and out_pixel_o stable for the whole stall. On release, there is no loss and no duplication, and order is preserved.
- Assert nreset_i mid-line → out_valid_o=0 immediately. After release and start_i, the new frame matches the reference model. start_i issued mid-line with a beat in the same cycle → that beat is treated as (0,0).

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types, widths and helpers for the streaming 3x3 Sobel block.
package sobel_pkg;

    typedef enum logic [1:0] {
        SOBEL_SUM    = 2'd0,
        SOBEL_GX     = 2'd1,
        SOBEL_GY     = 2'd2,
        SOBEL_THRESH = 2'd3
    } sobel_mode_e;

    // Widths at the default pixel width; modules rebase the growth onto their own PIXEL_WIDTH.
    localparam int PIXEL_WIDTH_DEF = 8;
    localparam int GRAD_WIDTH      = PIXEL_WIDTH_DEF + 3;
    localparam int SUM_WIDTH       = PIXEL_WIDTH_DEF + 4;

    function automatic logic [31:0] saturate(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel history; tail is the pixel written DEPTH shifts ago.
module sobel_line_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] pixel,
    output logic [WIDTH-1:0] tail
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    // Pure storage: contents survive reset and frame start, border masking hides stale lines.
    always_ff @(posedge clk) begin
        if (shift_en) mem <= {mem[DEPTH-2:0], pixel};
    end

    assign tail = mem[DEPTH-1];

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel: line buffers build the window, then gradient and magnitude stages.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int LINE_WIDTH  = 64,
    parameter int OUT_WIDTH   = 8
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic                   start_i,
    input  logic                   in_valid_i,
    input  logic [PIXEL_WIDTH-1:0] in_pixel_i,
    output logic                   in_ready_o,
    input  logic [1:0]             mode_i,
    input  logic [OUT_WIDTH-1:0]   threshold_i,
    output logic                   out_valid_o,
    output logic [OUT_WIDTH-1:0]   out_pixel_o,
    input  logic                   out_ready_i
);

    localparam int GW = GRAD_WIDTH - PIXEL_WIDTH_DEF + PIXEL_WIDTH;
    localparam int SW = SUM_WIDTH - PIXEL_WIDTH_DEF + PIXEL_WIDTH;
    localparam int CW = $clog2(LINE_WIDTH);

    logic                   advance, accept;
    logic [CW-1:0]          col, eff_col;
    logic [1:0]             row, eff_row;
    logic [PIXEL_WIDTH-1:0] lb1_tail, lb2_tail;
    logic [2:0]             vld_pipe;

    assign advance     = !(out_valid_o && !out_ready_i);
    assign in_ready_o  = advance;
    assign accept      = in_valid_i && advance;
    assign out_valid_o = vld_pipe[2];
    // A beat accepted alongside start_i is pixel (0,0) of the new frame.
    assign eff_col     = start_i ? '0 : col;
    assign eff_row     = start_i ? 2'd0 : row;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            col <= '0;
            row <= 2'd0;
        end else if (accept) begin
            if (eff_col == CW'(LINE_WIDTH - 1)) begin
                col <= '0;
                row <= (eff_row == 2'd2) ? 2'd2 : eff_row + 2'd1;
            end else begin
                col <= eff_col + 1'b1;
                row <= eff_row;
            end
        end else if (start_i) begin
            col <= '0;
            row <= 2'd0;
        end
    end

    sobel_line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(PIXEL_WIDTH)) u_lb1 (
        .clk(clk_i), .shift_en(accept), .pixel(in_pixel_i), .tail(lb1_tail)
    );

    sobel_line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(PIXEL_WIDTH)) u_lb2 (
        .clk(clk_i), .shift_en(accept), .pixel(lb1_tail), .tail(lb2_tail)
    );

    // win[r][c]: r=0 oldest line, c=2 newest column.
    logic [2:0][2:0][PIXEL_WIDTH-1:0] win;
    logic                             s0_border, s1_border;
    sobel_mode_e                      s0_mode, s1_mode;
    logic [OUT_WIDTH-1:0]             s0_thr, s1_thr;
    logic signed [GW-1:0]             px [3][3];
    logic signed [GW-1:0]             gx_c, gy_c, gx, gy;

    always_comb begin
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                px[r][c] = $signed({{(GW - PIXEL_WIDTH){1'b0}}, win[r][c]});
        gx_c = (px[0][2] - px[0][0]) + ((px[1][2] - px[1][0]) <<< 1) + (px[2][2] - px[2][0]);
        gy_c = (px[2][0] - px[0][0]) + ((px[2][1] - px[0][1]) <<< 1) + (px[2][2] - px[0][2]);
    end

    logic [GW-1:0]        abs_gx, abs_gy;
    logic [SW-1:0]        mag_sum;
    logic [OUT_WIDTH-1:0] sat_gx, sat_gy, sat_sum, result;

    always_comb begin
        abs_gx  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        abs_gy  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag_sum = SW'(abs_gx) + SW'(abs_gy);
        sat_gx  = OUT_WIDTH'(saturate(32'(abs_gx), OUT_WIDTH));
        sat_gy  = OUT_WIDTH'(saturate(32'(abs_gy), OUT_WIDTH));
        sat_sum = OUT_WIDTH'(saturate(32'(mag_sum), OUT_WIDTH));
        result  = '0;
        case (s1_mode)
            SOBEL_SUM:    result = sat_sum;
            SOBEL_GX:     result = sat_gx;
            SOBEL_GY:     result = sat_gy;
            SOBEL_THRESH: result = (sat_sum >= s1_thr) ? '1 : '0;
            default:      result = '0;
        endcase
        if (s1_border) result = '0;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            vld_pipe    <= '0;
            win         <= '0;
            s0_border   <= 1'b0;
            s0_mode     <= SOBEL_SUM;
            s0_thr      <= '0;
            gx          <= '0;
            gy          <= '0;
            s1_border   <= 1'b0;
            s1_mode     <= SOBEL_SUM;
            s1_thr      <= '0;
            out_pixel_o <= '0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[1:0], accept};
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb2_tail;
                win[1][2] <= lb1_tail;
                win[2][2] <= in_pixel_i;
                s0_border <= (eff_row < 2'd2) || (eff_col < CW'(2));
                s0_mode   <= sobel_mode_e'(mode_i);
                s0_thr    <= threshold_i;
            end
            gx          <= gx_c;
            gy          <= gy_c;
            s1_border   <= s0_border;
            s1_mode     <= s0_mode;
            s1_thr      <= s0_thr;
            out_pixel_o <= result;
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream with an 8-pixel line and 6-line frames.
module tb_sobel_stream;

    localparam int PW = 8, LW = 8, OW = 8, ROWS = 6, NPIX = ROWS * LW;

    logic          clk_i = 1'b0;
    logic          nreset_i, start_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [PW-1:0] in_pixel_i;
    logic [1:0]    mode_i;
    logic [OW-1:0] threshold_i, out_pixel_o;
    int            total = 0, bad = 0;
    logic [7:0]    img [ROWS][LW];
    logic [7:0]    got [$];
    logic [7:0]    hold;

    always #5 clk_i = ~clk_i;

    sobel_stream #(.PIXEL_WIDTH(PW), .LINE_WIDTH(LW), .OUT_WIDTH(OW)) dut (
        .clk_i(clk_i), .nreset_i(nreset_i), .start_i(start_i),
        .in_valid_i(in_valid_i), .in_pixel_i(in_pixel_i), .in_ready_o(in_ready_o),
        .mode_i(mode_i), .threshold_i(threshold_i),
        .out_valid_o(out_valid_o), .out_pixel_o(out_pixel_o), .out_ready_i(out_ready_i)
    );

    always @(negedge clk_i)
        if (nreset_i && out_valid_o && out_ready_i) got.push_back(out_pixel_o);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic logic [7:0] model(input int r, input int c, input logic [1:0] m, input int thr);
        int p [3][3];
        int gx, gy, ax, ay;
        if (r < 2 || c < 2) return 8'd0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) p[i][j] = int'(img[r-2+i][c-2+j]);
        gx = (p[0][2] - p[0][0]) + 2 * (p[1][2] - p[1][0]) + (p[2][2] - p[2][0]);
        gy = (p[2][0] - p[0][0]) + 2 * (p[2][1] - p[0][1]) + (p[2][2] - p[0][2]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        case (m)
            2'd0:    return 8'(sat(ax + ay));
            2'd1:    return 8'(sat(ax));
            2'd2:    return 8'(sat(ay));
            default: return (sat(ax + ay) >= thr) ? 8'd255 : 8'd0;
        endcase
    endfunction

    task automatic drive_beat(input logic [7:0] pix, input logic st, input logic [1:0] m, input logic [7:0] thr);
        bit acc = 0;
        in_valid_i = 1'b1; in_pixel_i = pix; start_i = st; mode_i = m; threshold_i = thr;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk_i); #1;
            acc = in_ready_o;
            @(posedge clk_i); #1;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready_o=%0b want 1 within 50 cycles", in_ready_o);
        end
        in_valid_i = 1'b0; start_i = 1'b0;
    endtask

    task automatic stream_frame(input logic [1:0] ma, input logic [1:0] mb, input int split, input logic [7:0] thr);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < LW; c++)
                drive_beat(img[r][c], (r == 0 && c == 0), (r < split) ? ma : mb, thr);
    endtask

    task automatic drain();
        repeat (8) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        nreset_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0; in_pixel_i = '0;
        mode_i = 2'd0; threshold_i = '0; out_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid_o); end
        total++; if (out_pixel_o !== 8'd0) begin bad++; $display("FAIL reset_pixel: got %0d want 0", out_pixel_o); end
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", in_ready_o); end
        nreset_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_latency();
        got.delete();
        in_valid_i = 1'b1; in_pixel_i = 8'd7; start_i = 1'b1; mode_i = 2'd0;
        @(negedge clk_i); #1;
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL lat_ready: got %0b want 1", in_ready_o); end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL lat_n0: got %0b want 0", out_valid_o); end
        @(negedge clk_i);
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL lat_n1: got %0b want 0", out_valid_o); end
        @(negedge clk_i);
        total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL lat_n2: got %0b want 1", out_valid_o); end
        total++; if (out_pixel_o !== 8'd0) begin bad++; $display("FAIL lat_pixel: got %0d want 0", out_pixel_o); end
        drain();
    endtask

    task automatic test_flat();
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < LW; c++) img[r][c] = 8'd100;
        got.delete();
        stream_frame(2'd0, 2'd0, ROWS, 8'd0);
        drain();
        total++; if (got.size() != NPIX) begin bad++; $display("FAIL flat_count: got %0d want %0d", got.size(), NPIX); end
        for (int i = 0; i < got.size() && i < NPIX; i++) begin
            total++; if (got[i] !== 8'd0) begin bad++; $display("FAIL flat idx=%0d got %0d want 0", i, got[i]); end
        end
    endtask

    task automatic test_ramp();
        logic [1:0] ma [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
        logic [1:0] mb [4] = '{2'd0, 2'd1, 2'd2, 2'd1};
        int         ea [4] = '{8, 8, 0, 0};
        int         eb [4] = '{8, 8, 0, 8};
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < LW; c++) img[r][c] = 8'(c);
        for (int k = 0; k < 4; k++) begin
            got.delete();
            stream_frame(ma[k], mb[k], 4, 8'd0);
            drain();
            total++; if (got.size() != NPIX) begin bad++; $display("FAIL ramp%0d_count: got %0d want %0d", k, got.size(), NPIX); end
            for (int i = 0; i < got.size() && i < NPIX; i++) begin
                int r = i / LW, c = i % LW;
                int e = (r < 2 || c < 2) ? 0 : ((r < 4) ? ea[k] : eb[k]);
                total++; if (got[i] !== 8'(e)) begin bad++; $display("FAIL ramp%0d idx=%0d got %0d want %0d", k, i, got[i], e); end
            end
        end
    endtask

    task automatic test_step();
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < LW; c++) img[r][c] = (c < 4) ? 8'd0 : 8'd255;
        for (int k = 0; k < 2; k++) begin
            got.delete();
            stream_frame((k == 0) ? 2'd0 : 2'd2, (k == 0) ? 2'd0 : 2'd2, ROWS, 8'd0);
            drain();
            total++; if (got.size() != NPIX) begin bad++; $display("FAIL step%0d_count: got %0d want %0d", k, got.size(), NPIX); end
            for (int i = 0; i < got.size() && i < NPIX; i++) begin
                int r = i / LW, c = i % LW;
                int e = (k == 0 && r >= 2 && (c == 4 || c == 5)) ? 255 : 0;
                total++; if (got[i] !== 8'(e)) begin bad++; $display("FAIL step%0d idx=%0d got %0d want %0d", k, i, got[i], e); end
            end
        end
    endtask

    task automatic test_threshold();
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < LW; c++) img[r][c] = 8'(c);
        for (int k = 0; k < 2; k++) begin
            got.delete();
            stream_frame(2'd3, 2'd3, ROWS, (k == 0) ? 8'd8 : 8'd9);
            drain();
            total++; if (got.size() != NPIX) begin bad++; $display("FAIL thr%0d_count: got %0d want %0d", k, got.size(), NPIX); end
            for (int i = 0; i < got.size() && i < NPIX; i++) begin
                int r = i / LW, c = i % LW;
                int e = (k == 0 && r >= 2 && c >= 2) ? 255 : 0;
                total++; if (got[i] !== 8'(e)) begin bad++; $display("FAIL thr%0d idx=%0d got %0d want %0d", k, i, got[i], e); end
            end
        end
    endtask

    task automatic test_stall();
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < LW; c++) img[r][c] = 8'(c);
        got.delete();
        fork
            stream_frame(2'd0, 2'd0, ROWS, 8'd0);
            begin
                repeat (20) @(posedge clk_i);
                #1;
                out_ready_i = 1'b0;
                hold = out_pixel_o;
                total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL stall_pre_valid: got %0b want 1", out_valid_o); end
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk_i); #1;
                    total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL stall_ready c%0d: got %0b want 0", j, in_ready_o); end
                    total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL stall_valid c%0d: got %0b want 1", j, out_valid_o); end
                    total++; if (out_pixel_o !== hold) begin bad++; $display("FAIL stall_pixel c%0d: got %0d want %0d", j, out_pixel_o, hold); end
                    @(posedge clk_i); #1;
                end
                out_ready_i = 1'b1;
            end
        join
        drain();
        total++; if (got.size() != NPIX) begin bad++; $display("FAIL stall_count: got %0d want %0d", got.size(), NPIX); end
        for (int i = 0; i < got.size() && i < NPIX; i++) begin
            int r = i / LW, c = i % LW;
            int e = (r >= 2 && c >= 2) ? 8 : 0;
            total++; if (got[i] !== 8'(e)) begin bad++; $display("FAIL stall idx=%0d got %0d want %0d", i, got[i], e); end
        end
    endtask

    task automatic test_reset_midframe();
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < LW; c++) img[r][c] = 8'($urandom_range(0, 60));
        for (int i = 0; i < 13; i++) drive_beat(img[i / LW][i % LW], (i == 0), 2'd0, 8'd0);
        total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL rst_pre_valid: got %0b want 1", out_valid_o); end
        nreset_i = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %0b want 0", out_valid_o); end
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %0b want 1", in_ready_o); end
        repeat (2) @(posedge clk_i);
        #1;
        nreset_i = 1'b1;
        got.delete();
        @(posedge clk_i); #1;
        // three beats at (0,0..2), then a frame whose start lands mid-line
        for (int i = 0; i < 3; i++) drive_beat(8'hAA, 1'b0, 2'd0, 8'd0);
        stream_frame(2'd0, 2'd2, 4, 8'd0);
        drain();
        total++; if (got.size() != NPIX + 3) begin bad++; $display("FAIL rst_count: got %0d want %0d", got.size(), NPIX + 3); end
        for (int i = 0; i < got.size() && i < NPIX + 3; i++) begin
            logic [7:0] e;
            int r = (i - 3) / LW, c = (i - 3) % LW;
            e = (i < 3) ? 8'd0 : model(r, c, (r < 4) ? 2'd0 : 2'd2, 0);
            total++; if (got[i] !== e) begin bad++; $display("FAIL rst_frame idx=%0d got %0d want %0d", i, got[i], e); end
        end
    endtask

    task automatic test_random_modes();
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < LW; c++) img[r][c] = 8'($urandom_range(0, 60));
        got.delete();
        stream_frame(2'd1, 2'd3, 4, 8'd60);
        drain();
        total++; if (got.size() != NPIX) begin bad++; $display("FAIL rnd_count: got %0d want %0d", got.size(), NPIX); end
        for (int i = 0; i < got.size() && i < NPIX; i++) begin
            logic [7:0] e;
            int r = i / LW, c = i % LW;
            e = model(r, c, (r < 4) ? 2'd1 : 2'd3, 60);
            total++; if (got[i] !== e) begin bad++; $display("FAIL rnd idx=%0d got %0d want %0d", i, got[i], e); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_flat();
        test_ramp();
        test_step();
        test_threshold();
        test_stall();
        test_reset_midframe();
        test_random_modes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
